// File: rtl/rat_recovery_ctrl.sv
// Rename-table recovery sequencer: after a redirect, drives one OVERWRITE_RAT cycle,
// then walks surviving ROB entries two per cycle to replay their renames.
module rat_recovery_ctrl #(
    parameter int ROB_IDX_W = 6,
    parameter int PREG_W    = 6
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 redirect_valid,
    input  logic [ROB_IDX_W:0]   redirect_robidx,
    input  logic [ROB_IDX_W:0]   rob_head,
    output logic [ROB_IDX_W-1:0] walk_rd0_idx,
    output logic [ROB_IDX_W-1:0] walk_rd1_idx,
    input  logic                 walk_rd0_need_to_wb,
    input  logic [4:0]           walk_rd0_lrd,
    input  logic [PREG_W-1:0]    walk_rd0_prd,
    input  logic                 walk_rd1_need_to_wb,
    input  logic [4:0]           walk_rd1_lrd,
    input  logic [PREG_W-1:0]    walk_rd1_prd,
    output logic [1:0]           rob_state,
    output logic                 rob_walk0_valid,
    output logic [4:0]           rob_walk0_lrd,
    output logic [PREG_W-1:0]    rob_walk0_prd,
    output logic                 rob_walk1_valid,
    output logic [4:0]           rob_walk1_lrd,
    output logic [PREG_W-1:0]    rob_walk1_prd,
    output logic                 rename_stall,
    output logic                 commit_block,
    output logic                 walk_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OVW  = 2'd1,
        S_WALK = 2'd2
    } state_t;

    localparam logic [ROB_IDX_W:0]   PTR_ONE = 1;
    localparam logic [ROB_IDX_W:0]   PTR_TWO = 2;
    localparam logic [ROB_IDX_W-1:0] IDX_ONE = 1;

    state_t               r_state;
    logic [ROB_IDX_W:0]   r_walk_ptr;
    logic [ROB_IDX_W:0]   r_remain;

    logic                 w_in_walk;
    logic                 w_walking;
    logic                 w_last;
    logic [ROB_IDX_W:0]   w_step;
    logic [ROB_IDX_W:0]   w_cnt;

    // cnt is inclusive of both ends; a full ROB (depth entries) still fits in ROB_IDX_W+1 bits.
    assign w_cnt     = redirect_robidx - rob_head + PTR_ONE;
    assign w_in_walk = (r_state == S_WALK);
    assign w_walking = w_in_walk & ~redirect_valid;
    assign w_last    = (r_remain <= PTR_TWO);
    assign w_step    = w_last ? r_remain : PTR_TWO;

    assign walk_rd0_idx = r_walk_ptr[ROB_IDX_W-1:0];
    assign walk_rd1_idx = r_walk_ptr[ROB_IDX_W-1:0] + IDX_ONE;

    assign rob_state = r_state;

    // A redirect arriving mid-walk suppresses that cycle's lanes: the walk is being restarted.
    assign rob_walk0_valid = w_walking & (r_remain != '0) & walk_rd0_need_to_wb;
    assign rob_walk1_valid = w_walking & (r_remain > PTR_ONE) & walk_rd1_need_to_wb;
    assign rob_walk0_lrd   = w_in_walk ? walk_rd0_lrd : '0;
    assign rob_walk0_prd   = w_in_walk ? walk_rd0_prd : '0;
    assign rob_walk1_lrd   = w_in_walk ? walk_rd1_lrd : '0;
    assign rob_walk1_prd   = w_in_walk ? walk_rd1_prd : '0;
    assign walk_done       = w_walking & w_last;

    assign rename_stall = reset_n & ((r_state != S_IDLE) | redirect_valid);
    assign commit_block = rename_stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_walk_ptr <= '0;
            r_remain   <= '0;
        end else if (redirect_valid) begin
            r_remain   <= w_cnt;
            r_walk_ptr <= rob_head;
            r_state    <= S_OVW;
        end else begin
            case (r_state)
                S_OVW: r_state <= S_WALK;
                S_WALK: begin
                    r_remain   <= r_remain - w_step;
                    r_walk_ptr <= r_walk_ptr + w_step;
                    if (w_last) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rat_recovery_ctrl.sv
// Directed bench for rat_recovery_ctrl: ROB read data comes from a bench-owned table,
// every walk cycle is checked against hand-chosen head/robidx vectors.
module tb_rat_recovery_ctrl;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OVW  = 2'd1;
    localparam logic [1:0] ST_WALK = 2'd2;

    logic       clock;
    logic       reset_n;
    logic       redirect_valid;
    logic [6:0] redirect_robidx;
    logic [6:0] rob_head;
    logic [5:0] walk_rd0_idx, walk_rd1_idx;
    logic       walk_rd0_need_to_wb, walk_rd1_need_to_wb;
    logic [4:0] walk_rd0_lrd, walk_rd1_lrd;
    logic [5:0] walk_rd0_prd, walk_rd1_prd;
    logic [1:0] rob_state;
    logic       rob_walk0_valid, rob_walk1_valid;
    logic [4:0] rob_walk0_lrd, rob_walk1_lrd;
    logic [5:0] rob_walk0_prd, rob_walk1_prd;
    logic       rename_stall, commit_block, walk_done;

    logic       nwb_m [64];
    logic [4:0] lrd_m [64];
    logic [5:0] prd_m [64];

    int total = 0;
    int bad   = 0;

    rat_recovery_ctrl #(.ROB_IDX_W(6), .PREG_W(6)) dut (
        .clock(clock), .reset_n(reset_n),
        .redirect_valid(redirect_valid), .redirect_robidx(redirect_robidx), .rob_head(rob_head),
        .walk_rd0_idx(walk_rd0_idx), .walk_rd1_idx(walk_rd1_idx),
        .walk_rd0_need_to_wb(walk_rd0_need_to_wb), .walk_rd0_lrd(walk_rd0_lrd), .walk_rd0_prd(walk_rd0_prd),
        .walk_rd1_need_to_wb(walk_rd1_need_to_wb), .walk_rd1_lrd(walk_rd1_lrd), .walk_rd1_prd(walk_rd1_prd),
        .rob_state(rob_state),
        .rob_walk0_valid(rob_walk0_valid), .rob_walk0_lrd(rob_walk0_lrd), .rob_walk0_prd(rob_walk0_prd),
        .rob_walk1_valid(rob_walk1_valid), .rob_walk1_lrd(rob_walk1_lrd), .rob_walk1_prd(rob_walk1_prd),
        .rename_stall(rename_stall), .commit_block(commit_block), .walk_done(walk_done)
    );

    // ROB storage model: combinational read at the DUT-supplied addresses.
    assign walk_rd0_need_to_wb = nwb_m[walk_rd0_idx];
    assign walk_rd0_lrd        = lrd_m[walk_rd0_idx];
    assign walk_rd0_prd        = prd_m[walk_rd0_idx];
    assign walk_rd1_need_to_wb = nwb_m[walk_rd1_idx];
    assign walk_rd1_lrd        = lrd_m[walk_rd1_idx];
    assign walk_rd1_prd        = prd_m[walk_rd1_idx];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            redirect_valid  = 1'($urandom_range(0, 1));
            redirect_robidx = 7'($urandom_range(0, 127));
            rob_head        = 7'($urandom_range(0, 127));
            #1;
            total++;
            if (rob_state !== ST_IDLE || rob_walk0_valid !== 1'b0 || rob_walk1_valid !== 1'b0 ||
                rename_stall !== 1'b0 || commit_block !== 1'b0 || walk_done !== 1'b0) begin
                bad++;
                $display("FAIL reset[%0d]: state=%0d v=%b%b stall=%b/%b done=%b, expected 0 00 0/0 0",
                         i, rob_state, rob_walk0_valid, rob_walk1_valid, rename_stall, commit_block, walk_done);
            end
        end
        @(negedge clock);
        redirect_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        total++;
        if (rob_state !== ST_IDLE || rename_stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: state=%0d stall=%b, expected 0 0", rob_state, rename_stall);
        end
    endtask

    // One full recovery: redirect cycle, OVW cycle, ceil(exp_cnt/2) walk cycles, back to IDLE.
    task automatic test_walk(input string name, input logic [6:0] head, input logic [6:0] ridx, input int exp_cnt);
        int rem;
        logic [5:0] e0, e1;
        logic ev0, ev1, edone;
        @(negedge clock);
        rob_head = head; redirect_robidx = ridx; redirect_valid = 1'b1;
        #1;
        total++;
        if (rob_state !== ST_IDLE || rename_stall !== 1'b1 || commit_block !== 1'b1 ||
            rob_walk0_valid !== 1'b0 || rob_walk1_valid !== 1'b0 || walk_done !== 1'b0) begin
            bad++;
            $display("FAIL %s redirect: state=%0d stall=%b/%b v=%b%b done=%b, expected 0 1/1 00 0",
                     name, rob_state, rename_stall, commit_block, rob_walk0_valid, rob_walk1_valid, walk_done);
        end
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        total++;
        if (rob_state !== ST_OVW || rename_stall !== 1'b1 || rob_walk0_valid !== 1'b0 ||
            rob_walk1_valid !== 1'b0 || walk_done !== 1'b0) begin
            bad++;
            $display("FAIL %s ovw: state=%0d stall=%b v=%b%b done=%b, expected 1 1 00 0",
                     name, rob_state, rename_stall, rob_walk0_valid, rob_walk1_valid, walk_done);
        end
        for (int k = 0; k < (exp_cnt + 1) / 2; k++) begin
            @(negedge clock);
            #1;
            rem   = exp_cnt - 2 * k;
            e0    = head[5:0] + 6'(2 * k);
            e1    = e0 + 6'd1;
            ev0   = nwb_m[e0];
            ev1   = (rem > 1) && nwb_m[e1];
            edone = (rem <= 2);
            total++;
            if (rob_state !== ST_WALK || rename_stall !== 1'b1 || commit_block !== 1'b1) begin
                bad++;
                $display("FAIL %s walk%0d state: state=%0d stall=%b/%b, expected 2 1/1",
                         name, k, rob_state, rename_stall, commit_block);
            end
            total++;
            if (walk_rd0_idx !== e0 || walk_rd1_idx !== e1) begin
                bad++;
                $display("FAIL %s walk%0d idx: got %0d/%0d, expected %0d/%0d",
                         name, k, walk_rd0_idx, walk_rd1_idx, e0, e1);
            end
            total++;
            if (rob_walk0_valid !== ev0 || rob_walk1_valid !== ev1 || walk_done !== edone) begin
                bad++;
                $display("FAIL %s walk%0d valid: v=%b%b done=%b, expected %b%b %b",
                         name, k, rob_walk0_valid, rob_walk1_valid, walk_done, ev0, ev1, edone);
            end
            if (ev0) begin
                total++;
                if (rob_walk0_lrd !== lrd_m[e0] || rob_walk0_prd !== prd_m[e0]) begin
                    bad++;
                    $display("FAIL %s walk%0d lane0: lrd=%0d prd=%0d, expected %0d %0d",
                             name, k, rob_walk0_lrd, rob_walk0_prd, lrd_m[e0], prd_m[e0]);
                end
            end
            if (ev1) begin
                total++;
                if (rob_walk1_lrd !== lrd_m[e1] || rob_walk1_prd !== prd_m[e1]) begin
                    bad++;
                    $display("FAIL %s walk%0d lane1: lrd=%0d prd=%0d, expected %0d %0d",
                             name, k, rob_walk1_lrd, rob_walk1_prd, lrd_m[e1], prd_m[e1]);
                end
            end
        end
        @(negedge clock);
        #1;
        total++;
        if (rob_state !== ST_IDLE || rename_stall !== 1'b0 || commit_block !== 1'b0 ||
            walk_done !== 1'b0 || rob_walk0_valid !== 1'b0 || rob_walk1_valid !== 1'b0 ||
            rob_walk0_lrd !== 5'd0 || rob_walk1_prd !== 6'd0) begin
            bad++;
            $display("FAIL %s end: state=%0d stall=%b/%b done=%b v=%b%b lrd0=%0d prd1=%0d, expected idle, all 0",
                     name, rob_state, rename_stall, commit_block, walk_done, rob_walk0_valid,
                     rob_walk1_valid, rob_walk0_lrd, rob_walk1_prd);
        end
    endtask

    task automatic test_need_to_wb_pattern();
        nwb_m[30] = 1'b1; nwb_m[31] = 1'b0; nwb_m[32] = 1'b0; nwb_m[33] = 1'b1;
        test_walk("nwb_1001", 7'd30, 7'd33, 4);
        nwb_m[31] = 1'b1; nwb_m[32] = 1'b1;
    endtask

    task automatic test_restart();
        @(negedge clock);
        rob_head = 7'd20; redirect_robidx = 7'd23; redirect_valid = 1'b1;
        @(negedge clock);
        redirect_valid = 1'b0;
        @(negedge clock);
        redirect_robidx = 7'd21; redirect_valid = 1'b1;
        #1;
        total++;
        if (rob_state !== ST_WALK || rob_walk0_valid !== 1'b0 || rob_walk1_valid !== 1'b0 ||
            walk_done !== 1'b0 || rename_stall !== 1'b1 || commit_block !== 1'b1) begin
            bad++;
            $display("FAIL restart hit: state=%0d v=%b%b done=%b stall=%b/%b, expected 2 00 0 1/1",
                     rob_state, rob_walk0_valid, rob_walk1_valid, walk_done, rename_stall, commit_block);
        end
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        total++;
        if (rob_state !== ST_OVW || rename_stall !== 1'b1) begin
            bad++;
            $display("FAIL restart ovw: state=%0d stall=%b, expected 1 1", rob_state, rename_stall);
        end
        @(negedge clock);
        #1;
        total++;
        if (rob_state !== ST_WALK || walk_rd0_idx !== 6'd20 || walk_rd1_idx !== 6'd21 ||
            rob_walk0_valid !== 1'b1 || rob_walk1_valid !== 1'b1 || walk_done !== 1'b1 || rename_stall !== 1'b1) begin
            bad++;
            $display("FAIL restart walk: state=%0d idx=%0d/%0d v=%b%b done=%b stall=%b, expected 2 20/21 11 1 1",
                     rob_state, walk_rd0_idx, walk_rd1_idx, rob_walk0_valid, rob_walk1_valid, walk_done, rename_stall);
        end
        @(negedge clock);
        #1;
        total++;
        if (rob_state !== ST_IDLE || rename_stall !== 1'b0 || walk_done !== 1'b0) begin
            bad++;
            $display("FAIL restart end: state=%0d stall=%b done=%b, expected 0 0 0", rob_state, rename_stall, walk_done);
        end
    endtask

    task automatic test_reset_mid_walk();
        @(negedge clock);
        rob_head = 7'd0; redirect_robidx = 7'd20; redirect_valid = 1'b1;
        @(negedge clock);
        redirect_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        total++;
        if (rob_state !== ST_IDLE || walk_done !== 1'b0 || rob_walk0_valid !== 1'b0 ||
            rob_walk1_valid !== 1'b0 || rename_stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_walk: state=%0d done=%b v=%b%b stall=%b, expected 0 0 00 0",
                     rob_state, walk_done, rob_walk0_valid, rob_walk1_valid, rename_stall);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        total++;
        if (rob_state !== ST_IDLE || walk_done !== 1'b0 || walk_rd0_idx !== 6'd0) begin
            bad++;
            $display("FAIL reset_mid_walk after: state=%0d done=%b idx0=%0d, expected 0 0 0",
                     rob_state, walk_done, walk_rd0_idx);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            nwb_m[i] = 1'b1;
            lrd_m[i] = 5'(i + 3);
            prd_m[i] = 6'(i * 5 + 7);
        end
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_robidx = '0;
        rob_head = '0;
        test_reset();
        test_walk("basic", 7'd5, 7'd8, 4);
        test_walk("wrap", 7'h3E, 7'h41, 4);
        test_walk("odd_single", 7'd10, 7'd10, 1);
        test_walk("odd_three", 7'd40, 7'd42, 3);
        test_walk("full_depth", 7'h10, 7'h4F, 64);
        test_need_to_wb_pattern();
        test_restart();
        test_reset_mid_walk();
        test_walk("after_reset", 7'd1, 7'd2, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
